// File: rtl/isqrt_iter_unit.sv
// isqrt_iter_unit: multi-cycle integer square root, y = floor(sqrt(x)).
// One result bit per clock; a new request may chain on the result cycle.
module isqrt_iter_unit #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           x_vld,
    input  logic [W-1:0]   x,
    output logic           y_vld,
    output logic [W/2-1:0] y,
    output logic           busy,
    output logic           err_drop
);

    localparam int YW = W / 2;
    localparam int CW = $clog2(YW);

    if ((W % 2) != 0 || W < 4 || W > 64) begin : g_bad_w
        $error("isqrt_iter_unit: W must be even and within 4..64");
    end

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    op_q, op_d;
    logic [YW+1:0]   rem_q, rem_d;
    logic [YW-1:0]   root_q, root_d;
    logic [YW-1:0]   y_q, y_d;
    logic            err_q, err_d;

    logic [YW+3:0]   acc;
    logic [YW+3:0]   sub;
    logic [YW+3:0]   trial;
    logic [YW+1:0]   rem_nx;
    logic [YW-1:0]   root_nx;
    logic            load;

    // One digit step: try subtracting {root,01} from the partial remainder.
    always_comb begin
        acc   = {rem_q, op_q[W-1 -: 2]};
        sub   = {2'b00, root_q, 2'b01};
        trial = acc - sub;
        if (trial[YW+3]) begin
            rem_nx  = acc[YW+1:0];
            root_nx = {root_q[YW-2:0], 1'b0};
        end else begin
            rem_nx  = trial[YW+1:0];
            root_nx = {root_q[YW-2:0], 1'b1};
        end
    end

    // Next-state and datapath update; acceptance only in IDLE or DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rem_d   = rem_q;
        root_d  = root_q;
        y_d     = y_q;
        err_d   = err_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                load = x_vld;
            end
            CALC: begin
                if (x_vld) begin
                    err_d = 1'b1;
                end
                op_d   = op_q << 2;
                rem_d  = rem_nx;
                root_d = root_nx;
                if (cnt_q == CW'(YW - 1)) begin
                    state_d = DONE;
                    y_d     = root_nx;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                load    = x_vld;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (load) begin
            op_d    = x;
            rem_d   = '0;
            root_d  = '0;
            cnt_d   = '0;
            state_d = CALC;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            y_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            y_q     <= y_d;
            err_q   <= err_d;
        end
    end

    assign y_vld    = (state_q == DONE);
    assign busy     = (state_q == CALC);
    assign y        = y_q;
    assign err_drop = err_q;

endmodule

// File: tb/tb_isqrt_iter_unit.sv
// tb_isqrt_iter_unit: directed and randomized checks of isqrt_iter_unit
// against a cycle-level behavioural model of request/result timing.
module tb_isqrt_iter_unit;

    localparam int W  = 32;
    localparam int YW = W / 2;
    localparam int LAT = YW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          x_vld = 1'b0;
    logic [W-1:0]  x = '0;
    logic          y_vld;
    logic [YW-1:0] y;
    logic          busy;
    logic          err_drop;

    int n_vec = 0;
    int n_bad = 0;

    int  cyc = 0;
    bit  started = 0;
    bit  m_pend = 0;
    bit  m_err = 0;
    bit  m_fin;
    int  m_start = 0;
    int  m_done = 0;
    longint m_val = 0;
    longint m_y = 0;
    bit  exp_vld;
    int  n_exp_res = 0;
    int  n_dut_res = 0;

    isqrt_iter_unit #(.W(W)) dut (
        .clk(clk),
        .rst(rst),
        .x_vld(x_vld),
        .x(x),
        .y_vld(y_vld),
        .y(y),
        .busy(busy),
        .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    function automatic longint isqrt(input longint v);
        longint r;
        r = longint'($sqrt(real'(v)));
        while (r * r > v) r--;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Behavioural model: one request in flight, result LAT cycles later.
    always @(posedge clk) begin
        if (rst) begin
            started = 1;
            m_pend  = 0;
            m_err   = 0;
            m_y     = 0;
        end else if (started) begin
            m_fin = m_pend && (cyc == m_done);
            if (m_fin) m_pend = 0;
            if (x_vld) begin
                if (!m_pend) begin
                    m_pend  = 1;
                    m_start = cyc;
                    m_done  = cyc + LAT;
                    m_val   = isqrt(longint'(x));
                end else begin
                    m_err = 1;
                end
            end
        end
        cyc++;
    end

    // Compare DUT outputs with the model every cycle, mid-cycle.
    always @(negedge clk) begin
        if (started) begin
            exp_vld = m_pend && (cyc == m_done);
            if (exp_vld) begin
                m_y = m_val;
                n_exp_res++;
            end
            if (y_vld === 1'b1) n_dut_res++;
            chk("y_vld", 64'(y_vld), 64'(exp_vld));
            chk("y", 64'(y), 64'(m_y));
            chk("busy", 64'(busy),
                64'(m_pend && cyc > m_start && cyc < m_done));
            chk("err_drop", 64'(err_drop), 64'(m_err));
        end
    end

    task automatic send_now(input logic [W-1:0] v);
        x_vld = 1'b1;
        x     = v;
        @(negedge clk);
        x_vld = 1'b0;
    endtask

    task automatic wait_res(input int t0, input longint exp);
        bit got = 0;
        for (int k = 0; k < 45 && !got; k++) begin
            if (y_vld === 1'b1) got = 1;
            else @(negedge clk);
        end
        if (!got) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout: got no y_vld expected one (t0 %0d)", t0);
        end else begin
            chk("latency", 64'(cyc - t0), 64'(LAT));
            chk("y_lit", 64'(y), 64'(exp));
        end
    endtask

    task automatic run_one(input logic [W-1:0] v, input longint exp);
        int t0;
        t0 = cyc;
        send_now(v);
        wait_res(t0, exp);
    endtask

    initial begin
        int t0;
        int gap;
        int k;
        logic [W-1:0] v;

        chk("model_0", 64'(isqrt(0)), 64'd0);
        chk("model_15", 64'(isqrt(15)), 64'd3);
        chk("model_1e6", 64'(isqrt(1000000)), 64'd1000);
        chk("model_max", 64'(isqrt(64'hFFFF_FFFF)), 64'd65535);
        chk("model_sqm1", 64'(isqrt(64'hFFFE_0000)), 64'd65534);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_y", 64'(y), 64'd0);
        chk("rst_vld", 64'(y_vld), 64'd0);
        @(negedge clk);

        run_one(16, 4);
        repeat (2) @(negedge clk);
        run_one(0, 0);
        @(negedge clk);
        run_one(1, 1);
        @(negedge clk);
        run_one(15, 3);
        @(negedge clk);
        run_one(1000000, 1000);
        @(negedge clk);
        run_one(32'hFFFF_FFFF, 65535);
        @(negedge clk);
        run_one(32'hFFFE_0001, 65535);
        @(negedge clk);
        run_one(32'hFFFE_0000, 65534);
        repeat (3) @(negedge clk);

        run_one(25, 5);
        run_one(100, 10);
        run_one(9, 3);
        chk("chain_err", 64'(err_drop), 64'd0);
        repeat (2) @(negedge clk);

        t0 = cyc;
        send_now(49);
        repeat (4) @(negedge clk);
        send_now(81);
        chk("drop_err", 64'(err_drop), 64'd1);
        wait_res(t0, 7);
        repeat (25) @(negedge clk);
        chk("drop_sticky", 64'(err_drop), 64'd1);

        t0 = cyc;
        send_now(144);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_y", 64'(y), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_err", 64'(err_drop), 64'd0);
        while (cyc <= t0 + 40) @(negedge clk);
        chk("mid_rst_y2", 64'(y), 64'd0);
        run_one(4, 2);
        @(negedge clk);

        for (int i = 0; i < 2000; i++) begin
            k = int'($urandom_range(0, 3));
            if (k == 0) begin
                v = $urandom;
            end else if (k == 1) begin
                v = W'($urandom_range(0, 1000));
            end else begin
                v = W'($urandom_range(1, 65535));
                v = v * v;
                if (k == 3) v = v - 1;
            end
            t0 = cyc;
            send_now(v);
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(0, 10)) @(negedge clk);
                send_now($urandom);
            end
            wait_res(t0, isqrt(longint'(v)));
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(negedge clk);
        end

        repeat (LAT + 3) @(negedge clk);
        chk("result_count", 64'(n_dut_res), 64'(n_exp_res));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
